// File: rtl/led_trail_pkg.sv
// Shared constants and one-hot helpers for the LED comet-trail renderer.
package led_trail_pkg;

    localparam int BW_DEFAULT          = 4;
    localparam int DECAY_SHIFT_DEFAULT = 1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Full-scale brightness for a given counter width.
    function automatic int max_of(input int bw);
        return (1 << bw) - 1;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

    function automatic logic [2:0] onehot2idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_trail_cell.sv
// One LED of the trail: a brightness register that reloads or decays, and its
// PWM comparator output.
module led_trail_cell
    import led_trail_pkg::*;
#(
    parameter int BW          = BW_DEFAULT,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          decay,
    input  logic [BW-1:0] pwm_cnt,
    output logic          led
);

    localparam logic [BW-1:0] MAX = BW'(max_of(BW));

    logic [BW-1:0] bright_reg;

    // The comparator sees the brightness held before this edge, giving the
    // one-cycle lag from brightness change to pin change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_reg <= '0;
            led        <= 1'b0;
        end else begin
            if (load) begin
                bright_reg <= MAX;
            end else if (decay) begin
                bright_reg <= bright_reg >> DECAY_SHIFT;
            end
            led <= (pwm_cnt < bright_reg);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Renders a one-hot bouncing LED position as a PWM comet trail, tracking sweep
// direction, completed sweeps and malformed positions.
module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int BW          = BW_DEFAULT,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [7:0] pos,
    input  logic       clr_err,
    output logic [7:0] led,
    output logic       dir,
    output logic [7:0] sweep_cnt,
    output logic       err
);

    // Counter runs 0..MAX-1 so that brightness MAX is on for the whole period.
    localparam logic [BW-1:0] PWM_LAST = BW'(max_of(BW) - 1);

    logic [BW-1:0] pwm_cnt_reg;
    logic [2:0]    last_idx_reg;
    logic          dir_reg;
    logic [7:0]    sweep_cnt_reg;
    logic          err_reg;

    logic          pos_ok;
    logic          step_ok;
    logic          step_bad;
    logic [2:0]    idx;

    assign pos_ok   = is_onehot(pos);
    assign idx      = onehot2idx(pos);
    assign step_ok  = step & pos_ok;
    assign step_bad = step & ~pos_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
        end else if (pwm_cnt_reg == PWM_LAST) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + BW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cell
            led_trail_cell #(
                .BW          (BW),
                .DECAY_SHIFT (DECAY_SHIFT)
            ) u_cell (
                .clk     (clk),
                .reset   (reset),
                .load    (step_ok && (idx == 3'(gi))),
                .decay   (step_ok && (idx != 3'(gi))),
                .pwm_cnt (pwm_cnt_reg),
                .led     (led[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_reg       <= DIR_UP;
            last_idx_reg  <= '0;
            sweep_cnt_reg <= '0;
        end else if (step_ok) begin
            if (idx > last_idx_reg) begin
                dir_reg <= DIR_UP;
            end else if (idx < last_idx_reg) begin
                dir_reg <= DIR_DOWN;
            end
            // A sweep completes when the comet lands home coming down from bit 1.
            if ((idx == 3'd0) && (last_idx_reg == 3'd1)) begin
                sweep_cnt_reg <= sweep_cnt_reg + 8'd1;
            end
            last_idx_reg <= idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (step_bad) begin
            err_reg <= 1'b1;
        end else if (clr_err) begin
            err_reg <= 1'b0;
        end
    end

    assign dir       = dir_reg;
    assign sweep_cnt = sweep_cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: stimulus queues hand-computed expectations
// tagged with the cycle they mature on; a negedge monitor pops and compares them.
module tb_led_trail_pwm;

    logic       clk;
    logic       reset;
    logic       step;
    logic [7:0] pos;
    logic       clr_err;
    logic [7:0] led;
    logic       dir;
    logic [7:0] sweep_cnt;
    logic       err;

    led_trail_pwm #(.BW(4), .DECAY_SHIFT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .pos       (pos),
        .clr_err   (clr_err),
        .led       (led),
        .dir       (dir),
        .sweep_cnt (sweep_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: dir/sweep_cnt/err, kind 1: exact led byte, kind 2: on-cycles of one
    // led bit over the last 15 cycles (one full PWM period, equals brightness).
    typedef struct {
        int         cyc;
        int         kind;
        int         tag;
        logic [7:0] e8;
        logic       e_dir;
        int         esw;
        logic       e_err;
        int         ecount;
        int         bitn;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    logic [7:0] hist[16];
    int         wexp[8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int tag, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s (test %0d) cycle %0d: got %0d, required %0d", name, tag, cyc, act, req);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   i;
        int   cnt;
        hist[cyc % 16] = led;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc > cyc) begin
                i++;
            end else begin
                e = sb[i];
                sb.delete(i);
                if (e.cyc < cyc) begin
                    check("stale_entry", e.tag, cyc, e.cyc);
                end else if (e.kind == 0) begin
                    check("dir", e.tag, int'(dir), int'(e.e_dir));
                    check("sweep_cnt", e.tag, int'(sweep_cnt), e.esw);
                    check("err", e.tag, int'(err), int'(e.e_err));
                end else if (e.kind == 1) begin
                    check("led", e.tag, int'(led), int'(e.e8));
                end else begin
                    cnt = 0;
                    for (int k = 0; k < 15; k++) begin
                        cnt += int'(hist[(cyc - k) % 16][e.bitn]);
                    end
                    check($sformatf("led%0d_on_cycles", e.bitn), e.tag, cnt, e.ecount);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_state(input int c, input logic edir, input int esw, input logic eerr, input int tag);
        exp_t e;
        e = '{cyc: c, kind: 0, tag: tag, e8: 8'h00, e_dir: edir, esw: esw, e_err: eerr, ecount: 0, bitn: 0};
        sb.push_back(e);
    endtask

    task automatic push_led(input int c, input logic [7:0] v, input int tag);
        exp_t e;
        e = '{cyc: c, kind: 1, tag: tag, e8: v, e_dir: 1'b0, esw: 0, e_err: 1'b0, ecount: 0, bitn: 0};
        sb.push_back(e);
    endtask

    task automatic push_windows(input int tag);
        exp_t e;
        for (int b = 0; b < 8; b++) begin
            e = '{cyc: cyc + 15, kind: 2, tag: tag, e8: 8'h00, e_dir: 1'b0, esw: 0, e_err: 1'b0,
                  ecount: wexp[b], bitn: b};
            sb.push_back(e);
        end
    endtask

    task automatic set_wexp(input int b0, input int b1, input int b2, input int b3, input int b4);
        wexp = '{b0, b1, b2, b3, b4, 0, 0, 0};
    endtask

    // Called at a negedge; inputs are captured on the next posedge.
    task automatic apply(input logic stp, input logic [7:0] p, input logic clr,
                         input logic edir, input int esw, input logic eerr, input int tag);
        step    = stp;
        pos     = p;
        clr_err = clr;
        push_state(cyc + 1, edir, esw, eerr, tag);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        step    = 1'b0;
        pos     = 8'h00;
        clr_err = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_mid(input int tag);
        #2 reset = 1'b1;
        #1;
        check("rst_led", tag, int'(led), 0);
        check("rst_dir", tag, int'(dir), 0);
        check("rst_sweep_cnt", tag, int'(sweep_cnt), 0);
        check("rst_err", tag, int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) push_led(cyc + k, 8'h00, tag);
        push_state(cyc + 1, 1'b0, 0, 1'b0, tag);
        idle(21);
    endtask

    initial begin
        int sw;
        reset   = 1'b1;
        step    = 1'b0;
        pos     = 8'h00;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        check("init_led", 0, int'(led), 0);
        check("init_dir", 0, int'(dir), 0);
        check("init_sweep_cnt", 0, int'(sweep_cnt), 0);
        check("init_err", 0, int'(err), 0);
        reset = 1'b0;
        idle(2);

        // Test 3: trail build-up and fade to zero.
        apply(1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b0, 3);
        apply(1'b1, 8'h02, 1'b0, 1'b0, 0, 1'b0, 3);
        apply(1'b1, 8'h04, 1'b0, 1'b0, 0, 1'b0, 3);
        set_wexp(3, 7, 15, 0, 0);
        push_windows(3);
        idle(16);
        apply(1'b1, 8'h08, 1'b0, 1'b0, 0, 1'b0, 3);
        apply(1'b1, 8'h10, 1'b0, 1'b0, 0, 1'b0, 3);
        set_wexp(0, 1, 3, 7, 15);
        push_windows(3);
        idle(16);

        // Test 4: invalid positions leave the trail alone; set beats clear.
        apply(1'b1, 8'h03, 1'b0, 1'b0, 0, 1'b1, 4);
        set_wexp(0, 1, 3, 7, 15);
        push_windows(4);
        idle(16);
        apply(1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b1, 4);
        apply(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 4);
        apply(1'b1, 8'h08, 1'b0, 1'b1, 0, 1'b0, 4);
        set_wexp(0, 0, 1, 15, 7);
        push_windows(4);
        idle(16);

        // Test 1: reset mid-stream with err and dir set.
        apply(1'b1, 8'h05, 1'b0, 1'b1, 0, 1'b1, 1);
        idle(2);
        reset_mid(1);

        // Test 2: single home step, then steady full brightness.
        push_led(cyc + 1, 8'h00, 2);
        for (int k = 2; k <= 31; k++) push_led(cyc + k, 8'h01, 2);
        apply(1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b0, 2);
        idle(32);

        // Test 5: one generator sweep including home dwell.
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b0, 5);
            idle(1);
        end
        for (int k = 1; k < 8; k++) begin
            apply(1'b1, 8'(1 << k), 1'b0, 1'b0, 0, 1'b0, 5);
            idle(1);
        end
        for (int k = 6; k >= 1; k--) begin
            apply(1'b1, 8'(1 << k), 1'b0, 1'b1, 0, 1'b0, 5);
            idle(1);
        end
        apply(1'b1, 8'h01, 1'b0, 1'b1, 1, 1'b0, 5);
        idle(1);
        apply(1'b1, 8'h01, 1'b0, 1'b1, 1, 1'b0, 5);
        set_wexp(15, 3, 1, 0, 0);
        push_windows(5);
        idle(16);

        // Test 6: 256 back-to-back sweeps, counter wraps through 255 -> 0.
        sw = 1;
        for (int s = 0; s < 256; s++) begin
            apply(1'b1, 8'h01, 1'b0, 1'b1, sw, 1'b0, 6);
            for (int k = 1; k < 8; k++) apply(1'b1, 8'(1 << k), 1'b0, 1'b0, sw, 1'b0, 6);
            for (int k = 6; k >= 1; k--) apply(1'b1, 8'(1 << k), 1'b0, 1'b1, sw, 1'b0, 6);
            sw = (sw + 1) % 256;
            apply(1'b1, 8'h01, 1'b0, 1'b1, sw, 1'b0, 6);
        end
        idle(2);

        // Final reset with a non-zero sweep count and err set.
        apply(1'b1, 8'hFF, 1'b0, 1'b1, sw, 1'b1, 7);
        idle(2);
        reset_mid(7);

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) check("drain", 0, sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
